// File: rtl/sr_cmd_seq.sv
// rtl/sr_cmd_seq.sv - SR flip-flop command sequencer with one-deep pending slot
module sr_cmd_seq #(
    parameter int PULSE_W = 2,
    parameter int GUARD_W = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic set_req_i,
    input  logic clr_req_i,
    input  logic tog_req_i,
    output logic s_o,
    output logic r_o,
    output logic busy_o,
    output logic q_shadow_o,
    output logic conflict_o,
    output logic drop_o
);

    typedef enum logic [1:0] {IDLE, PULSE, GUARD} state_t;
    typedef enum logic [1:0] {CMD_SET, CMD_CLR, CMD_TOG} cmd_t;

    localparam logic [3:0] P_LOAD = 4'(PULSE_W - 1);
    localparam logic [3:0] G_LOAD = 4'(GUARD_W - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       set_prev, clr_prev, tog_prev;
    logic       slot_valid;
    cmd_t       slot_cmd;

    logic       set_e, clr_e, tog_e;
    logic [1:0] n_edges;
    logic       single, multi;
    cmd_t       edge_cmd;
    logic       pulse_done, guard_done;
    logic       slot_launch, edge_launch, launch_go, launch_s;
    cmd_t       launch_cmd;

    always_comb begin
        set_e    = set_req_i & ~set_prev;
        clr_e    = clr_req_i & ~clr_prev;
        tog_e    = tog_req_i & ~tog_prev;
        n_edges  = {1'b0, set_e} + {1'b0, clr_e} + {1'b0, tog_e};
        single   = (n_edges == 2'd1);
        multi    = (n_edges >= 2'd2);
        edge_cmd = set_e ? CMD_SET : (clr_e ? CMD_CLR : CMD_TOG);

        // With no guard configured, the end of the pulse is also the end of the guard.
        pulse_done  = (state == PULSE) && (cnt == 4'd0);
        guard_done  = ((state == GUARD) && (cnt == 4'd0)) || (pulse_done && (GUARD_W == 0));
        slot_launch = slot_valid && ((state == IDLE) || guard_done);
        edge_launch = (state == IDLE) && !slot_valid && single;
        launch_go   = slot_launch || edge_launch;
        launch_cmd  = slot_valid ? slot_cmd : edge_cmd;
        // Toggles are resolved against the shadow at launch, not arrival.
        launch_s    = (launch_cmd == CMD_SET) || ((launch_cmd == CMD_TOG) && !q_shadow_o);
    end

    assign busy_o = (state != IDLE) || slot_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            set_prev   <= 1'b0;
            clr_prev   <= 1'b0;
            tog_prev   <= 1'b0;
            slot_valid <= 1'b0;
            slot_cmd   <= CMD_SET;
            s_o        <= 1'b0;
            r_o        <= 1'b0;
            q_shadow_o <= 1'b0;
            conflict_o <= 1'b0;
            drop_o     <= 1'b0;
        end else begin
            set_prev   <= set_req_i;
            clr_prev   <= clr_req_i;
            tog_prev   <= tog_req_i;
            conflict_o <= multi;
            drop_o     <= 1'b0;

            // A slot launching this cycle is free for a newly arriving request.
            if (single && !edge_launch) begin
                if (!slot_valid || slot_launch) begin
                    slot_valid <= 1'b1;
                    slot_cmd   <= edge_cmd;
                end else begin
                    drop_o <= 1'b1;
                end
            end else if (slot_launch) begin
                slot_valid <= 1'b0;
            end

            if (launch_go) begin
                state      <= PULSE;
                cnt        <= P_LOAD;
                s_o        <= launch_s;
                r_o        <= !launch_s;
                q_shadow_o <= launch_s;
            end else begin
                case (state)
                    PULSE: begin
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            s_o <= 1'b0;
                            r_o <= 1'b0;
                            if (GUARD_W == 0) begin
                                state <= IDLE;
                            end else begin
                                state <= GUARD;
                                cnt   <= G_LOAD;
                            end
                        end
                    end
                    GUARD: begin
                        if (cnt != 4'd0) cnt <= cnt - 4'd1;
                        else             state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sr_cmd_seq.sv
// tb/tb_sr_cmd_seq.sv - directed self-checking bench for sr_cmd_seq
module tb_sr_cmd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, set_req, clr_req, tog_req;
    logic s, r, busy, q, conf, drop;

    logic reset2, set2, zero2;
    logic s2, r2, busy2, q2, conf2, drop2;

    logic [5:0] obs, obs2, exp_v;
    assign obs  = {s, r, busy, q, conf, drop};
    assign obs2 = {s2, r2, busy2, q2, conf2, drop2};

    int n_checks = 0;
    int n_fail   = 0;

    sr_cmd_seq dut (
        .clk(clk), .reset(reset),
        .set_req_i(set_req), .clr_req_i(clr_req), .tog_req_i(tog_req),
        .s_o(s), .r_o(r), .busy_o(busy), .q_shadow_o(q),
        .conflict_o(conf), .drop_o(drop)
    );

    sr_cmd_seq #(.PULSE_W(1), .GUARD_W(0)) dut2 (
        .clk(clk), .reset(reset2),
        .set_req_i(set2), .clr_req_i(zero2), .tog_req_i(zero2),
        .s_o(s2), .r_o(r2), .busy_o(busy2), .q_shadow_o(q2),
        .conflict_o(conf2), .drop_o(drop2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Vectors below are {s, r, busy, q, conflict, drop} observed just after edge i.
    task automatic test_reset();
        reset = 1'b1; set_req = 1'b0; clr_req = 1'b0; tog_req = 1'b0;
        step(); step();
        n_checks++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected %b", obs, 6'b0);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected %b", obs, 6'b0);
        end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 14; i++) begin
            tog_req = (i == 0 || i == 10);
            step();
            exp_v = {(i <= 1), (i == 10 || i == 11), (i <= 2 || (i >= 10 && i <= 12)),
                     (i < 10), 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL toggle edge %0d: got %b expected %b", i, obs, exp_v);
            end
        end
        tog_req = 1'b0;
    endtask

    task automatic test_single_set();
        for (int i = 0; i < 10; i++) begin
            set_req = (i >= 3);
            step();
            exp_v = {(i == 3 || i == 4), 1'b0, (i >= 3 && i <= 5), (i >= 3), 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL single_set edge %0d: got %b expected %b", i, obs, exp_v);
            end
        end
        set_req = 1'b0;
        step(); step();
    endtask

    task automatic test_conflict();
        for (int i = 0; i < 6; i++) begin
            set_req = (i < 2);
            clr_req = (i < 2);
            step();
            exp_v = {1'b0, 1'b0, 1'b0, 1'b1, (i == 0), 1'b0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL conflict edge %0d: got %b expected %b", i, obs, exp_v);
            end
        end
        set_req = 1'b0; clr_req = 1'b0;
    endtask

    task automatic test_queue_drop();
        for (int i = 0; i < 9; i++) begin
            set_req = (i == 0);
            clr_req = (i == 1);
            tog_req = (i == 2);
            step();
            exp_v = {(i <= 1), (i == 3 || i == 4), (i <= 5), (i <= 2), 1'b0, (i == 2)};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL queue_drop edge %0d: got %b expected %b", i, obs, exp_v);
            end
        end
        set_req = 1'b0; clr_req = 1'b0; tog_req = 1'b0;
    endtask

    task automatic test_reset_mid_pulse();
        for (int i = 0; i < 8; i++) begin
            set_req = (i == 0);
            clr_req = (i == 1);
            reset   = (i == 2);
            step();
            exp_v = (i <= 1) ? 6'b101100 : 6'b000000;
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid_pulse edge %0d: got %b expected %b", i, obs, exp_v);
            end
        end
        set_req = 1'b0; clr_req = 1'b0; reset = 1'b0;
    endtask

    task automatic test_held_through_reset();
        reset2 = 1'b1;
        set2   = 1'b1;
        step(); step();
        n_checks++;
        if (obs2 !== 6'b0) begin
            n_fail++;
            $display("FAIL held_reset_state: got %b expected %b", obs2, 6'b0);
        end
        reset2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_v = {(i == 0), 1'b0, (i == 0), 1'b1, 1'b0, 1'b0};
            n_checks++;
            if (obs2 !== exp_v) begin
                n_fail++;
                $display("FAIL held_no_guard edge %0d: got %b expected %b", i, obs2, exp_v);
            end
        end
        set2 = 1'b0;
    endtask

    initial begin
        reset2 = 1'b1; set2 = 1'b0; zero2 = 1'b0;
        test_reset();
        test_toggle();
        test_single_set();
        test_conflict();
        test_queue_drop();
        test_reset_mid_pulse();
        test_held_through_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    always @(negedge clk) begin
        if ((s & r) === 1'b1 || (s2 & r2) === 1'b1) begin
            $error("FAIL sr_exclusive: s=%b r=%b s2=%b r2=%b", s, r, s2, r2);
        end
    end

endmodule
